// File: rtl/tex_unpack_pkg.sv
// Shared definitions for the texel unpacker: format class codes, the
// red/blue swap bit position and the UNORM bit-replication expanders.
package tex_unpack_pkg;

    localparam logic [1:0] TEX_CLS_R8       = 2'b00;
    localparam logic [1:0] TEX_CLS_RGB565   = 2'b01;
    localparam logic [1:0] TEX_CLS_RGBA8888 = 2'b10;
    localparam logic [1:0] TEX_CLS_RGBA4444 = 2'b11;

    // format bit that swaps red and blue (or selects luminance in class R8)
    localparam int TEX_SWAP_BIT = 2;

    // Replicate MSB-first and truncate to 32 bits: 0 -> 0, all-ones -> all-ones.
    function automatic logic [31:0] expand8(input logic [7:0] x);
        return {4{x}};
    endfunction

    function automatic logic [31:0] expand6(input logic [5:0] x);
        return {{5{x}}, x[5:4]};
    endfunction

    function automatic logic [31:0] expand5(input logic [4:0] x);
        return {{6{x}}, x[4:3]};
    endfunction

    function automatic logic [31:0] expand4(input logic [3:0] x);
        return {8{x}};
    endfunction

endpackage

// File: rtl/tex_unpack_fifo.sv
// Synchronous FIFO holding raw texel entries (data, format, tag).
// DEPTH must be a power of two so the pointers wrap naturally.
module tex_unpack_fifo
    import tex_unpack_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next-state; a simultaneous push and pop nets zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/tex_texel_unpack.sv
// Texel unpacker: buffers raw texture-memory words and expands them into
// four 32-bit UNORM channels behind a registered valid/ready output stage.
// Optional build macro ANFFL_TEX_UNPACK_LUMA_EN: class R8 with the swap bit
// set is decoded as luminance (r = g = b); otherwise the swap bit is ignored
// for R8.
module tex_texel_unpack
    import tex_unpack_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_format,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [31:0]      out_g,
    output logic [31:0]      out_b,
    output logic [31:0]      out_a,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int FW = 32 + 5 + TAG_W;

    logic          fifo_full, fifo_empty;
    logic          push, pop;
    logic [FW-1:0] fifo_rdata;

    logic [31:0]      hd_data;
    logic [4:0]       hd_fmt;
    logic [TAG_W-1:0] hd_tag;
    logic [1:0]       hd_cls;
    logic             hd_swap;
    logic             fmt_rsvd_unused;

    logic [31:0] ch_r, ch_b, dec_r, dec_g, dec_b, dec_a;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      r_q, r_d, g_q, g_d, b_q, b_d, a_q, a_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // A full FIFO refuses input even if it is draining this cycle.
    assign in_ready = !fifo_full && !flush && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && (!out_valid_q || out_ready) && !flush && !reset;

    tex_unpack_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata ({in_tag, in_format, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hd_data         = fifo_rdata[31:0];
    assign hd_fmt          = fifo_rdata[36:32];
    assign hd_tag          = fifo_rdata[FW-1:37];
    assign hd_cls          = hd_fmt[1:0];
    assign hd_swap         = hd_fmt[TEX_SWAP_BIT];
    assign fmt_rsvd_unused = ^hd_fmt[4:3];

    // Combinational decode of the FIFO head into expanded channels.
    always_comb begin
        ch_r  = '0;
        ch_b  = '0;
        dec_g = '0;
        dec_a = '1;
        case (hd_cls)
            TEX_CLS_R8: begin
                ch_r = expand8(hd_data[7:0]);
`ifdef ANFFL_TEX_UNPACK_LUMA_EN
                if (hd_swap) begin
                    dec_g = ch_r;
                    ch_b  = ch_r;
                end
`endif
            end
            TEX_CLS_RGB565: begin
                ch_r  = expand5(hd_data[15:11]);
                dec_g = expand6(hd_data[10:5]);
                ch_b  = expand5(hd_data[4:0]);
            end
            TEX_CLS_RGBA8888: begin
                ch_r  = expand8(hd_data[7:0]);
                dec_g = expand8(hd_data[15:8]);
                ch_b  = expand8(hd_data[23:16]);
                dec_a = expand8(hd_data[31:24]);
            end
            default: begin
                ch_r  = expand4(hd_data[3:0]);
                dec_g = expand4(hd_data[7:4]);
                ch_b  = expand4(hd_data[11:8]);
                dec_a = expand4(hd_data[15:12]);
            end
        endcase
        dec_r = ch_r;
        dec_b = ch_b;
        if (hd_swap && (hd_cls != TEX_CLS_R8)) begin
            dec_r = ch_b;
            dec_b = ch_r;
        end
    end

    // Output stage next-state: flush drops the texel, a load replaces it,
    // an accepted texel with nothing behind it empties the stage.
    always_comb begin
        out_valid_d = out_valid_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        a_d         = a_q;
        tag_d       = tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (pop) begin
            out_valid_d = 1'b1;
            r_d         = dec_r;
            g_d         = dec_g;
            b_d         = dec_b;
            a_d         = dec_a;
            tag_d       = hd_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage register; reset clears channels and tag as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            a_q         <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            a_q         <= a_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = r_q;
    assign out_g     = g_q;
    assign out_b     = b_q;
    assign out_a     = a_q;
    assign out_tag   = tag_q;
    assign busy      = !fifo_empty || out_valid_q;

endmodule
